// File: rtl/layer1_result_writer.sv
// Layer-1 write-back controller: stores one result per filter for each window
// position at its filter-major address, then asks the loader for the next window.
// Optional build macro LAYER1_WRITER_RELU_EN clamps negative results to zero.
module layer1_result_writer #(
    parameter int DATA_W  = 8,
    parameter int NUM_FIL = 4,
    parameter int OUT_DIM = 13,
    parameter int ADDR_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      resValid,
    input  logic [NUM_FIL*DATA_W-1:0] resData,
    output logic                      resReady,
    output logic                      ldBuf,
    output logic                      memWrEn,
    output logic [ADDR_W-1:0]         memWrIdx,
    output logic [DATA_W-1:0]         memWrData,
    output logic                      busy,
    output logic                      finished
);

    localparam int POS_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int FIL_W = (NUM_FIL > 1) ? $clog2(NUM_FIL) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(OUT_DIM - 1);
    localparam logic [FIL_W-1:0] LAST_FIL = FIL_W'(NUM_FIL - 1);

    typedef enum logic [2:0] {IDLE, WAIT_RES, WRITE, REQ, DONE} state_t;

    state_t                      state;
    logic [POS_W-1:0]            row;
    logic [POS_W-1:0]            col;
    logic [FIL_W-1:0]            fil;
    logic [FIL_W-1:0]            fil_next;
    logic [NUM_FIL*DATA_W-1:0]   hold;

    assign fil_next = fil + FIL_W'(1);

    function automatic logic [ADDR_W-1:0] write_index(input logic [FIL_W-1:0] f,
                                                      input logic [POS_W-1:0] r,
                                                      input logic [POS_W-1:0] c);
        return ADDR_W'(f) * ADDR_W'(OUT_DIM * OUT_DIM) + ADDR_W'(r) * ADDR_W'(OUT_DIM) + ADDR_W'(c);
    endfunction

    function automatic logic [DATA_W-1:0] write_data(input logic [NUM_FIL*DATA_W-1:0] bank,
                                                     input logic [FIL_W-1:0] f);
        logic [DATA_W-1:0] v;
        v = bank[f*DATA_W +: DATA_W];
`ifdef LAYER1_WRITER_RELU_EN
        if (v[DATA_W-1])
            v = '0;
`endif
        return v;
    endfunction

    // Outputs are registered alongside the state, so each is loaded with the
    // value belonging to the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            fil       <= '0;
            hold      <= '0;
            resReady  <= 1'b0;
            ldBuf     <= 1'b0;
            memWrEn   <= 1'b0;
            memWrIdx  <= '0;
            memWrData <= '0;
            busy      <= 1'b0;
            finished  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= WAIT_RES;
                        row      <= '0;
                        col      <= '0;
                        fil      <= '0;
                        resReady <= 1'b1;
                        busy     <= 1'b1;
                        finished <= 1'b0;
                    end
                end
                WAIT_RES: begin
                    if (resValid) begin
                        state     <= WRITE;
                        hold      <= resData;
                        fil       <= '0;
                        resReady  <= 1'b0;
                        memWrEn   <= 1'b1;
                        memWrIdx  <= write_index('0, row, col);
                        memWrData <= write_data(resData, '0);
                    end
                end
                WRITE: begin
                    if (fil == LAST_FIL) begin
                        fil       <= '0;
                        memWrEn   <= 1'b0;
                        memWrIdx  <= '0;
                        memWrData <= '0;
                        if (row == LAST_POS && col == LAST_POS) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            finished <= 1'b1;
                        end else begin
                            state <= REQ;
                            ldBuf <= 1'b1;
                            if (col == LAST_POS) begin
                                col <= '0;
                                row <= row + POS_W'(1);
                            end else begin
                                col <= col + POS_W'(1);
                            end
                        end
                    end else begin
                        fil       <= fil_next;
                        memWrIdx  <= write_index(fil_next, row, col);
                        memWrData <= write_data(hold, fil_next);
                    end
                end
                REQ: begin
                    state    <= WAIT_RES;
                    ldBuf    <= 1'b0;
                    resReady <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
